paddle_ctrl: RTL and testbench

Game-level sequencer for the two paddles and the ball enable. It sits between the raw player inputs (buttons, optional CPU opponent) and the two paddle position blocks. It runs the IDLE/SERVE/PLAY/PAUSED game state machine and gates paddle commands by state. It also resolves conflicting up/down requests and rate-limits movement with a tick divider.

---
 rtl/paddle_ctrl_pkg.sv | 21 ++
 rtl/paddle_ctrl_paddle_cmd.sv | 26 ++
 rtl/paddle_ctrl.sv | 159 +++++++++++++++
 tb/tb_paddle_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_ctrl_pkg.sv
// Shared game definitions: state encoding, playfield constants and a
// helper telling which game states let the paddles move.
package paddle_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_PAUSED = 2'd3
    } game_state_t;

    // Playfield geometry shared with the paddle position blocks.
    localparam int Y_MAX        = 280;
    localparam int PADDLE_H_DEF = 200;

    // Paddles may move while serving and while playing.
    function automatic logic moves_allowed(input game_state_t s);
        return (s == ST_SERVE) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/paddle_ctrl_paddle_cmd.sv
// Per-paddle command stage: drops conflicting up+down requests, gates
// by game state and the rate strobe, and registers the result.
module paddle_cmd (
    input  logic game_clk,
    input  logic rst,
    input  logic strobe,
    input  logic move_en,
    input  logic req_up,
    input  logic req_down,
    output logic up_o,
    output logic down_o
);

    // Register one-cycle move commands; move_en reflects the state the
    // game enters on this edge, so a pause clears a pending move at once.
    always_ff @(posedge game_clk) begin
        if (rst) begin
            up_o   <= 1'b0;
            down_o <= 1'b0;
        end else begin
            up_o   <= strobe && move_en && req_up && !req_down;
            down_o <= strobe && move_en && req_down && !req_up;
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Game-level sequencer: IDLE/SERVE/PLAY/PAUSED FSM, ball enable, rate
// divider and gated paddle commands. Optional CPU opponent for paddle 2
// is compiled in when CPU_PLAYER_EN is defined.
// No valid/ready handshakes here: all inputs are levels or one-cycle
// pulses sampled on every game_clk edge.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int SPEED_DIV   = 1,
    parameter int SERVE_TICKS = 120,
    parameter int PADDLE_H    = PADDLE_H_DEF,
    parameter int DEADBAND    = 4
) (
    input  logic       game_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       score_evt,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       cpu_mode,
    input  logic [9:0] ball_y,
    input  logic [9:0] p2_y,
    output logic       p1_up_o,
    output logic       p1_down_o,
    output logic       p2_up_o,
    output logic       p2_down_o,
    output logic       ball_en,
    output logic [1:0] state
);

    localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int SRV_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SPEED_DIV - 1);
    localparam logic [SRV_W-1:0] SERVE_LOAD = SRV_W'(SERVE_TICKS - 1);

    game_state_t      state_q, state_d;
    logic [SRV_W-1:0] serve_q, serve_d;
    logic [DIV_W-1:0] div_q;
    logic             strobe;
    logic             move_en;
    logic             p2_req_up, p2_req_down;

    // Rate divider: free-running 0..SPEED_DIV-1 in every state.
    always_ff @(posedge game_clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (strobe) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign strobe = (div_q == DIV_LAST);

    // FSM state and serve countdown registers.
    always_ff @(posedge game_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            serve_q <= '0;
        end else begin
            state_q <= state_d;
            serve_q <= serve_d;
        end
    end

    // Next-state logic; score_evt outranks pause in PLAY.
    always_comb begin
        state_d = state_q;
        serve_d = serve_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SERVE;
                    serve_d = SERVE_LOAD;
                end
            end
            ST_SERVE: begin
                if (serve_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    serve_d = serve_q - SRV_W'(1);
                end
            end
            ST_PLAY: begin
                if (score_evt) begin
                    state_d = ST_SERVE;
                    serve_d = SERVE_LOAD;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state   = state_q;
    assign ball_en = (state_q == ST_PLAY);
    assign move_en = moves_allowed(state_d);

`ifdef CPU_PLAYER_EN
    logic [10:0] cpu_center;
    logic [10:0] cpu_ball;
    logic        cpu_up, cpu_down;

    // CPU tracking: steer paddle-2 center toward the ball outside a deadband.
    always_comb begin
        cpu_center  = {1'b0, p2_y} + 11'(PADDLE_H / 2);
        cpu_ball    = {1'b0, ball_y};
        cpu_down    = (cpu_center + 11'(DEADBAND)) < cpu_ball;
        cpu_up      = cpu_center > (cpu_ball + 11'(DEADBAND));
        p2_req_up   = cpu_mode ? cpu_up   : p2_up;
        p2_req_down = cpu_mode ? cpu_down : p2_down;
    end
`else
    logic unused_cpu_inputs;

    // Without the CPU opponent paddle 2 follows its buttons only.
    always_comb begin
        p2_req_up   = p2_up;
        p2_req_down = p2_down;
    end

    assign unused_cpu_inputs = ^{cpu_mode, ball_y, p2_y};
`endif

    paddle_cmd u_p1 (
        .game_clk (game_clk),
        .rst      (rst),
        .strobe   (strobe),
        .move_en  (move_en),
        .req_up   (p1_up),
        .req_down (p1_down),
        .up_o     (p1_up_o),
        .down_o   (p1_down_o)
    );

    paddle_cmd u_p2 (
        .game_clk (game_clk),
        .rst      (rst),
        .strobe   (strobe),
        .move_en  (move_en),
        .req_up   (p2_req_up),
        .req_down (p2_req_down),
        .up_o     (p2_up_o),
        .down_o   (p2_down_o)
    );

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: two instances (SPEED_DIV 1 and 3, SERVE_TICKS 4)
// share one stimulus stream; a behavioural game model predicts both.
// CPU tracking steps are active when CPU_PLAYER_EN is defined.
module tb_paddle_ctrl;

    localparam int SERVE_T  = 4;
    localparam int PAD_H    = 200;
    localparam int DEADBAND = 4;

    // ---------------- clock / reset ----------------
    logic game_clk;
    logic rst;
    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    logic       start, pause, score_evt;
    logic       p1_up, p1_down, p2_up, p2_down, cpu_mode;
    logic [9:0] ball_y, p2_y;

    logic       a_p1u, a_p1d, a_p2u, a_p2d, a_ball;
    logic [1:0] a_state;
    logic       b_p1u, b_p1d, b_p2u, b_p2d, b_ball;
    logic [1:0] b_state;

    paddle_ctrl #(.SPEED_DIV(1), .SERVE_TICKS(SERVE_T), .PADDLE_H(PAD_H), .DEADBAND(DEADBAND)) dut_a (
        .game_clk(game_clk), .rst(rst), .start(start), .pause(pause), .score_evt(score_evt),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .cpu_mode(cpu_mode), .ball_y(ball_y), .p2_y(p2_y),
        .p1_up_o(a_p1u), .p1_down_o(a_p1d), .p2_up_o(a_p2u), .p2_down_o(a_p2d),
        .ball_en(a_ball), .state(a_state)
    );

    paddle_ctrl #(.SPEED_DIV(3), .SERVE_TICKS(SERVE_T), .PADDLE_H(PAD_H), .DEADBAND(DEADBAND)) dut_b (
        .game_clk(game_clk), .rst(rst), .start(start), .pause(pause), .score_evt(score_evt),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .cpu_mode(cpu_mode), .ball_y(ball_y), .p2_y(p2_y),
        .p1_up_o(b_p1u), .p1_down_o(b_p1d), .p2_up_o(b_p2u), .p2_down_o(b_p2d),
        .ball_en(b_ball), .state(b_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q[$];

    // Behavioural game model, one slot per instance.
    int       div_p[2] = '{1, 3};
    int       m_st[2];
    int       m_srv[2];
    int       m_div[2];
    bit [3:0] m_cmd[2];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        int  ns, nsrv;
        bit  strobe_m, mv, u2, d2;
        for (int i = 0; i < 2; i++) begin
            strobe_m = (m_div[i] == div_p[i] - 1);
            if (rst) begin
                m_st[i]  = 0;
                m_srv[i] = 0;
                m_div[i] = 0;
                m_cmd[i] = 4'b0000;
            end else begin
                ns   = m_st[i];
                nsrv = m_srv[i];
                case (m_st[i])
                    0: if (start) begin ns = 1; nsrv = SERVE_T - 1; end
                    1: if (m_srv[i] == 0) ns = 2; else nsrv = m_srv[i] - 1;
                    2: if (score_evt) begin ns = 1; nsrv = SERVE_T - 1; end
                       else if (pause) ns = 3;
                    default: if (pause) ns = 2;
                endcase
                mv = (ns == 1) || (ns == 2);
                u2 = p2_up;
                d2 = p2_down;
`ifdef CPU_PLAYER_EN
                if (cpu_mode) begin
                    u2 = (int'(p2_y) + PAD_H / 2) > (int'(ball_y) + DEADBAND);
                    d2 = (int'(p2_y) + PAD_H / 2 + DEADBAND) < int'(ball_y);
                end
`endif
                m_cmd[i][3] = strobe_m && mv && p1_up && !p1_down;
                m_cmd[i][2] = strobe_m && mv && p1_down && !p1_up;
                m_cmd[i][1] = strobe_m && mv && u2 && !d2;
                m_cmd[i][0] = strobe_m && mv && d2 && !u2;
                m_st[i]  = ns;
                m_srv[i] = nsrv;
                m_div[i] = (m_div[i] + 1) % div_p[i];
            end
            exp_q.push_back({2'(m_st[i]), 1'(m_st[i] == 2), m_cmd[i]});
        end
    endtask

    // One clock: model update at the edge, compare both instances 1ns later.
    task automatic tick();
        logic [6:0] e;
        @(posedge game_clk);
        model_step();
        #1;
        e = exp_q.pop_front();
        check("a_state",   8'(a_state), 8'(e[6:5]));
        check("a_ball_en", 8'(a_ball),  8'(e[4]));
        check("a_cmd",     8'({a_p1u, a_p1d, a_p2u, a_p2d}), 8'(e[3:0]));
        e = exp_q.pop_front();
        check("b_state",   8'(b_state), 8'(e[6:5]));
        check("b_ball_en", 8'(b_ball),  8'(e[4]));
        check("b_cmd",     8'({b_p1u, b_p1d, b_p2u, b_p2d}), 8'(e[3:0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        start = 0; pause = 0; score_evt = 0;
        p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
        cpu_mode = 0; ball_y = 10'd0; p2_y = 10'd0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int hits;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_srv[i] = 0; m_div[i] = 0; m_cmd[i] = 4'b0000;
        end
        clear_inputs();
        rst = 1;
        tick();
        tick();
        check("rst_state", 8'(a_state), 8'd0);
        check("rst_cmd", 8'({a_p1u, a_p1d, a_p2u, a_p2d, b_p1u, b_p1d, b_p2u, b_p2d}), 8'd0);
        check("rst_ball_en", 8'({a_ball, b_ball}), 8'd0);
        rst = 0;
        tick();
        check("idle_hold", 8'(a_state), 8'd0);

        // start -> SERVE for exactly SERVE_T cycles -> PLAY
        start = 1;
        tick();
        start = 0;
        check("serve_entry", 8'(a_state), 8'd1);
        for (int k = 0; k < SERVE_T - 1; k++) begin
            tick();
            check("serve_len", 8'(a_state), 8'd1);
        end
        tick();
        check("play_entry", 8'(a_state), 8'd2);
        check("ball_en_play", 8'(a_ball), 8'd1);

        // conflict on paddle 1, then up alone
        p1_up = 1; p1_down = 1;
        tick();
        check("conflict", 8'({a_p1u, a_p1d}), 8'd0);
        tick();
        p1_down = 0;
        tick();
        check("p1_up_alone", 8'(a_p1u), 8'd1);
        p1_up = 0;

        // rate limit on the SPEED_DIV=3 instance
        p2_down = 1;
        hits = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            hits += int'(b_p2d);
        end
        check("div3_rate", 8'(hits), 8'd3);
        p2_down = 0;

        // score and pause together: back to SERVE, pause dropped
        score_evt = 1; pause = 1;
        tick();
        score_evt = 0; pause = 0;
        check("score_wins", 8'(a_state), 8'd1);
        for (int k = 0; k < SERVE_T; k++) tick();
        check("replay", 8'(a_state), 8'd2);

        // pause with a move pending, then resume
        p1_up = 1;
        tick();
        pause = 1;
        tick();
        pause = 0;
        check("paused", 8'(a_state), 8'd3);
        check("paused_cmd", 8'({a_p1u, a_p1d, a_p2u, a_p2d}), 8'd0);
        check("paused_ball", 8'(a_ball), 8'd0);
        score_evt = 1;
        tick();
        score_evt = 0;
        check("paused_score_ign", 8'(a_state), 8'd3);
        pause = 1;
        tick();
        pause = 0;
        check("resume", 8'(a_state), 8'd2);
        p1_up = 0;

`ifdef CPU_PLAYER_EN
        // CPU tracking, buttons ignored while cpu_mode=1
        cpu_mode = 1; p2_y = 10'd100; p2_up = 1;
        ball_y = 10'd210;
        tick();
        check("cpu_down", 8'({a_p2u, a_p2d}), 8'b01);
        ball_y = 10'd190;
        tick();
        check("cpu_up", 8'({a_p2u, a_p2d}), 8'b10);
        ball_y = 10'd203;
        tick();
        check("cpu_dead", 8'({a_p2u, a_p2d}), 8'b00);
        cpu_mode = 0; p2_up = 0;
`else
        // cpu_mode has no effect without the tracker
        cpu_mode = 1; p2_y = 10'd100; ball_y = 10'd210; p2_up = 1;
        tick();
        check("no_cpu_btn", 8'({a_p2u, a_p2d}), 8'b10);
        cpu_mode = 0; p2_up = 0;
`endif

        // reset mid-play with everything held
        p1_up = 1; p2_down = 1; start = 1; pause = 1;
        rst = 1;
        tick();
        rst = 0;
        check("midrst_state", 8'({a_state, b_state}), 8'd0);
        check("midrst_cmd", 8'({a_p1u, a_p1d, a_p2u, a_p2d, b_p1u, b_p1d, b_p2u, b_p2d}), 8'd0);
        clear_inputs();

        // randomized play against the model
        for (int k = 0; k < 500; k++) begin
            rst       = ($urandom_range(0, 79) == 0);
            start     = ($urandom_range(0, 7) == 0);
            pause     = ($urandom_range(0, 9) == 0);
            score_evt = ($urandom_range(0, 11) == 0);
            p1_up     = 1'($urandom_range(0, 1));
            p1_down   = 1'($urandom_range(0, 1));
            p2_up     = 1'($urandom_range(0, 1));
            p2_down   = 1'($urandom_range(0, 1));
            cpu_mode  = 1'($urandom_range(0, 1));
            p2_y      = 10'($urandom_range(0, 800));
            ball_y    = p2_y + 10'($urandom_range(90, 110));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
